fft_stream_ctrl: RTL and testbench

//  Flow controller in front of and behind top_FFT (1024-pt streaming core, 24b samples {re[23:12],im[11:0]}).

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_valid_tag_pipe.sv | 35 +++
 rtl/fft_stream_ctrl.sv | 111 +++++++++++
 tb/tb_fft_stream_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg -- shared sizing constants and controller state encoding for the FFT stream wrapper (rev 1.0)
`default_nettype none

package fft_pkg;

  localparam int N_POINTS = 1024;
  localparam int LOG2N    = 10;
  localparam int DW       = 24;
  localparam int LATENCY  = 10;
  localparam int CNT_W    = $clog2(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fft_valid_tag_pipe.sv
// fft_valid_tag_pipe -- per-sample valid tags that travel alongside the core pipeline (rev 1.0)
`default_nettype none

module fft_valid_tag_pipe
  import fft_pkg::*;
#(
  parameter int DEPTH = LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic pop,
  input  logic din,
  output logic tail
);

  logic [DEPTH-1:0] tags;

  // A result taken downstream while the core is frozen must not be offered twice,
  // so its tag is retired even though nothing shifts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tags <= '0;
    end else if (en) begin
      tags <= {tags[DEPTH-2:0], din};
    end else if (pop) begin
      tags[DEPTH-1] <= 1'b0;
    end
  end

  assign tail = tags[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fft_stream_ctrl.sv
// fft_stream_ctrl -- valid/ready flow control, clock-enable stalling, padding and draining around a streaming FFT core (rev 1.0)
`default_nettype none

module fft_stream_ctrl
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  input  logic             flush,
  output logic             core_en,
  output logic [DW-1:0]    core_in,
  input  logic [DW-1:0]    core_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic             m_first,
  output logic             m_last,
  output logic [LOG2N-1:0] in_idx,
  output logic [15:0]      frame_cnt,
  output logic             busy
);

  localparam logic [LOG2N-1:0] IDX_LAST   = LOG2N'(N_POINTS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           state_nx;
  logic [LOG2N-1:0] out_idx;
  logic [LOG2N-1:0] in_idx_inc;
  logic [LOG2N-1:0] in_idx_post;
  logic [CNT_W-1:0] drain_cnt;
  logic             tag_tail;
  logic             tag_head;
  logic             in_open;
  logic             stall;
  logic             accept;
  logic             pad_adv;
  logic             drain_adv;
  logic             pop;

  assign m_valid     = reset & tag_tail;
  assign stall       = m_valid & ~m_ready;
  assign pop         = m_valid & m_ready;
  assign m_data      = core_out;
  assign m_first     = m_valid & (out_idx == '0);
  assign m_last      = m_valid & (out_idx == IDX_LAST);
  assign busy        = (state != ST_IDLE);
  assign in_idx_inc  = (in_idx == IDX_LAST) ? '0 : in_idx + 1'b1;
  // Flush decisions look at the index as it will be after this cycle's accept.
  assign in_idx_post = accept ? in_idx_inc : in_idx;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_RUN;
      ST_RUN:   if (flush) state_nx = (in_idx_post == '0) ? ST_DRAIN : ST_PAD;
      ST_PAD:   if (pad_adv && (in_idx == IDX_LAST)) state_nx = ST_DRAIN;
      ST_DRAIN: if (drain_adv && (drain_cnt == DRAIN_LAST)) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_open   = reset & ((state == ST_IDLE) | (state == ST_RUN));
    s_ready   = in_open & ~stall;
    accept    = s_valid & s_ready;
    pad_adv   = reset & ~stall & (state == ST_PAD);
    drain_adv = reset & ~stall & (state == ST_DRAIN);
    core_en   = accept | pad_adv | drain_adv;
    core_in   = in_open ? s_data : '0;
    tag_head  = (state != ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_idx    <= '0;
      out_idx   <= '0;
      drain_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if (accept || pad_adv) in_idx <= in_idx_inc;
      if (drain_adv) drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + 1'b1;
      if (pop) begin
        out_idx <= (out_idx == IDX_LAST) ? '0 : out_idx + 1'b1;
        if (out_idx == IDX_LAST) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  fft_valid_tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .en    (core_en),
    .pop   (pop),
    .din   (tag_head),
    .tail  (tag_tail)
  );

endmodule

`default_nettype wire

// File: tb/tb_fft_stream_ctrl.sv
// tb_fft_stream_ctrl -- directed stimulus with a queue-based model of the expected result stream (rev 1.0)
`default_nettype none

module tb_fft_stream_ctrl;
  import fft_pkg::*;

  localparam logic [DW-1:0] CORE_K = 24'hA5C396;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             s_valid = 1'b0;
  logic [DW-1:0]    s_data = '0;
  logic             flush = 1'b0;
  logic             m_ready = 1'b1;
  logic             s_ready;
  logic             core_en;
  logic [DW-1:0]    core_in;
  logic [DW-1:0]    core_out;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic             m_first;
  logic             m_last;
  logic [LOG2N-1:0] in_idx;
  logic [15:0]      frame_cnt;
  logic             busy;

  always #5 clk = ~clk;

  fft_stream_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .flush     (flush),
    .core_en   (core_en),
    .core_in   (core_in),
    .core_out  (core_out),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_first   (m_first),
    .m_last    (m_last),
    .in_idx    (in_idx),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  // Stand-in core: fixed LATENCY-step delay with enable and a per-sample transform.
  logic [DW-1:0] core_line [LATENCY];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) core_line[i] <= '0;
    end else if (core_en) begin
      core_line[0] <= core_in;
      for (int i = 1; i < LATENCY; i++) core_line[i] <= core_line[i-1];
    end
  end
  assign core_out = core_line[LATENCY-1] ^ CORE_K;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];
  int            in_cnt = 0;
  int            out_cnt = 0;
  int            cyc = 0;
  bit            active = 1'b0;
  int            adv_noacc = 0;
  int            stall_cyc = 0;
  int            acc0_cyc = 0;
  int            out0_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int f, input int i);
    logic [11:0] re;
    logic [11:0] im;
    re = 12'(i * 37 + f * 11);
    im = 12'(4095 - i * 5 + f * 301);
    return {re, im};
  endfunction

  task automatic send(input logic [DW-1:0] d, input bit fl);
    int t;
    s_valid = 1'b1;
    s_data  = d;
    flush   = fl;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 2000) begin
        check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
        break;
      end
      step();
    end
    step();
    s_valid = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n, input bit gaps, input bit fl_last);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 2)) step();
      send(pat(f, i), fl_last && (i == n - 1));
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      t++;
      if (t > 500) begin
        check("drain_timeout", {31'd0, busy}, 32'd0);
        break;
      end
    end
    step();
    repeat (3) step();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    int s0;
    fork
      forever begin : monitor
        bit acc;
        bit was_active;
        int pads;
        @(negedge clk);
        cyc++;
        if (!reset) begin
          check("rst_quiet", {29'd0, m_valid, s_ready, core_en}, 32'd0);
          check("rst_core_in", 32'(core_in), 32'd0);
          exp_q.delete();
          in_cnt  = 0;
          out_cnt = 0;
          active  = 1'b0;
        end else begin
          acc        = s_valid & s_ready;
          was_active = active;
          check("frame_cnt", 32'(frame_cnt), 32'((out_cnt / N_POINTS) % 65536));
          if (m_valid) begin
            if (exp_q.size() == 0) begin
              check("spurious_m_valid", {31'd0, m_valid}, 32'd0);
            end else begin
              check("m_data", 32'(m_data), 32'(exp_q[0]));
              check("m_first", {31'd0, m_first}, {31'd0, (out_cnt % N_POINTS) == 0});
              check("m_last", {31'd0, m_last}, {31'd0, (out_cnt % N_POINTS) == N_POINTS - 1});
              if (m_ready) begin
                void'(exp_q.pop_front());
                if (out_cnt % N_POINTS == 0) out0_cyc = cyc;
                out_cnt++;
              end
            end
          end else begin
            check("flags_no_valid", {30'd0, m_first, m_last}, 32'd0);
          end
          if (m_valid && !m_ready) begin
            stall_cyc++;
            check("stall_gate", {30'd0, s_ready, core_en}, 32'd0);
          end
          if (acc) begin
            check("in_idx", 32'(in_idx), 32'(in_cnt));
            check("core_in_pass", 32'(core_in), 32'(s_data));
            if (in_cnt == 0) acc0_cyc = cyc;
            exp_q.push_back(s_data ^ CORE_K);
            in_cnt = (in_cnt + 1) % N_POINTS;
            active = 1'b1;
          end
          if (was_active) check("core_en_run", {31'd0, core_en}, {31'd0, acc});
          if (core_en && !acc) begin
            adv_noacc++;
            check("pad_zero", 32'(core_in), 32'd0);
          end
          if (flush && was_active) begin
            pads = (N_POINTS - in_cnt) % N_POINTS;
            for (int k = 0; k < pads; k++) exp_q.push_back(CORE_K);
            in_cnt = 0;
            active = 1'b0;
          end
        end
      end
      begin : stimulus
        repeat (3) step();
        reset = 1'b1;
        step();

        // Back-to-back frame, then flush at a frame boundary.
        send_frame(1, 1024, 1'b0, 1'b0);
        pulse_flush();
        wait_idle();
        check("t1_latency", 32'(out0_cyc - acc0_cyc), 32'd10);
        check("t1_out_count", 32'(out_cnt), 32'd1024);
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Starved input every third cycle.
        send_frame(2, 1024, 1'b1, 1'b0);
        pulse_flush();
        wait_idle();
        check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Downstream backpressure for five cycles around result 500.
        s0 = stall_cyc;
        fork
          send_frame(3, 1024, 1'b0, 1'b0);
          begin
            for (int t = 0; t < 5000; t++) begin
              @(negedge clk);
              if (out_cnt >= 2548) break;
            end
            step();
            m_ready = 1'b0;
            repeat (5) step();
            m_ready = 1'b1;
          end
        join
        pulse_flush();
        wait_idle();
        check("t3_stall_cycles", 32'(stall_cyc - s0), 32'd5);
        check("t3_frame_cnt", 32'(frame_cnt), 32'd3);

        // Partial frame: 1000 samples, 24 pads then 10 drain steps.
        a0 = adv_noacc;
        send_frame(4, 1000, 1'b0, 1'b0);
        pulse_flush();
        wait_idle();
        check("t4_pad_drain_steps", 32'(adv_noacc - a0), 32'd34);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd4);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        reset = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Flush together with the last accept: drain only.
        a0 = adv_noacc;
        send_frame(5, 1024, 1'b0, 1'b1);
        wait_idle();
        check("t5_drain_steps", 32'(adv_noacc - a0), 32'd10);
        check("t5_out_count", 32'(out_cnt), 32'd1024);
        check("t5_frame_cnt", 32'(frame_cnt), 32'd1);

        // Reset in the middle of a frame.
        send_frame(6, 300, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        @(negedge clk);
        check("t6_m_valid", {31'd0, m_valid}, 32'd0);
        check("t6_in_idx", 32'(in_idx), 32'd0);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        step();
        send_frame(7, 1024, 1'b0, 1'b0);
        pulse_flush();
        wait_idle();
        check("t6_out_count", 32'(out_cnt), 32'd1024);
        check("t6_frame_cnt_after", 32'(frame_cnt), 32'd1);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
